// File: rtl/kpd_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// A frame result is five bits: bit 4 flags "no single key", bits 3:0 carry the hex code.
package kpd_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef logic [$clog2(NUM_COLS)-1:0] col_idx_t;
    typedef logic [$clog2(NUM_ROWS)-1:0] row_idx_t;
    typedef logic [4:0]                  result_t;

    localparam result_t RESULT_NONE = 5'b1_0000;

    // Indexed [column][row]; matches the printed legend of the hex keypad.
    localparam logic [3:0] KEY_MAP [0:NUM_COLS-1][0:NUM_ROWS-1] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

endpackage

// File: rtl/kpd_scan_timer.sv
// Column scan timebase: a prescaler that ticks once every SCAN_DIV cycles and
// a column index that advances on each tick, wrapping after the last column.
module kpd_scan_timer
    import kpd_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic     ck,
    input  logic     rst_n,
    output logic     tick,
    output col_idx_t idx
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + col_idx_t'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: synchronises the rows, forms a per-frame key result,
// debounces it across frames and shifts accepted keys into an 8-digit buffer.
module keypad_scanner
    import kpd_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] digits
);

    localparam int              DB_W   = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

    logic            tick;
    col_idx_t        idx;
    logic [3:0]      row_meta;
    logic [3:0]      row_sync;
    logic [2:0]      hits;
    row_idx_t        hit_row;
    logic [2:0]      sum;
    logic [1:0]      total;
    logic [1:0]      acc_cnt;
    logic [3:0]      acc_code;
    logic [3:0]      code_sel;
    logic            frame_end;
    result_t         frame_result;
    result_t         prev_result;
    result_t         stable;
    result_t         stable_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    state_t          state;
    state_t          state_nxt;
    logic            accept;

    kpd_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .ck    (ck),
        .rst_n (rst_n),
        .tick  (tick),
        .idx   (idx)
    );

    assign col      = ~(4'b0001 << idx);
    assign key_held = (state == PRESSED);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hits    = 3'd0;
        hit_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) begin
                hits    = hits + 3'd1;
                hit_row = row_idx_t'(r);
            end
        end
    end

    // Crossings saturate at two: anything beyond one key is already a reject.
    assign sum          = 3'(acc_cnt) + hits;
    assign total        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    assign code_sel     = (acc_cnt == 2'd0) ? KEY_MAP[idx][hit_row] : acc_code;
    assign frame_end    = tick && (idx == col_idx_t'(NUM_COLS - 1));
    assign frame_result = (total == 2'd1) ? {1'b0, code_sel} : RESULT_NONE;

    always_comb begin
        db_cnt_nxt = db_cnt;
        stable_nxt = stable;
        if (frame_end) begin
            if (frame_result == prev_result) begin
                db_cnt_nxt = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);
            end else begin
                db_cnt_nxt = DB_W'(1);
            end
            if (db_cnt_nxt == DB_MAX) begin
                stable_nxt = frame_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (!stable_nxt[4]) begin
                        state_nxt = PRESSED;
                        accept    = 1'b1;
                    end
                end
                PRESSED: begin
                    if (stable_nxt[4]) begin
                        state_nxt = IDLE;
                    end else if (stable_nxt[3:0] != key) begin
                        accept = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            row_meta    <= 4'hF;
            row_sync    <= 4'hF;
            acc_cnt     <= '0;
            acc_code    <= '0;
            prev_result <= RESULT_NONE;
            db_cnt      <= '0;
            stable      <= RESULT_NONE;
            key         <= '0;
            key_valid   <= 1'b0;
            digits      <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (tick) begin
                acc_cnt  <= frame_end ? 2'd0 : total;
                acc_code <= frame_end ? 4'h0 : code_sel;
            end
            if (frame_end) begin
                prev_result <= frame_result;
            end
            db_cnt    <= db_cnt_nxt;
            stable    <= stable_nxt;
            key_valid <= accept;
            if (accept) begin
                key <= stable_nxt[3:0];
            end
            // A clear in the same cycle as an accept drops that key as well.
            if (clr) begin
                digits <= '0;
            end else if (accept) begin
                digits <= {digits[27:0], stable_nxt[3:0]};
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised self-checking bench for keypad_scanner: a keypad model drives the
// rows from col, and a frame-level reference model predicts every output.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [31:0] digits;

    logic [15:0] mask = '0;   // pressed keys, bit r*4+c
    int checks = 0;
    int errors = 0;

    // Reference model state: frame-result history window and accepted key.
    int          hist[$];
    int          stable_m = -1;
    int          held_m   = -1;
    logic [3:0]  key_m    = '0;
    logic [31:0] digits_m = '0;

    // [row][col] legend of the keypad.
    int key_tbl [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .row       (row),
        .clr       (clr),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits)
    );

    always #5 ck = ~ck;

    // Passive matrix: a row reads low when a pressed key joins it to a driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (col[c] === 1'b0 && mask[r*4+c]) row[r] = 1'b0;
    end

    function automatic logic [15:0] mask_of(input int code);
        logic [15:0] m;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_tbl[r][c] == code) m = 16'(1) << (r * 4 + c);
        return m;
    endfunction

    function automatic int frame_result_of(input logic [15:0] m);
        int res;
        res = -1;
        if ($countones(m) == 1)
            for (int i = 0; i < 16; i++)
                if (m[i]) res = key_tbl[i / 4][i % 4];
        return res;
    endfunction

    function automatic void model_reset();
        hist.delete();
        stable_m = -1;
        held_m   = -1;
        key_m    = '0;
        digits_m = '0;
    endfunction

    function automatic bit model_frame(input logic [15:0] m, input bit clr_b);
        int res;
        bit acc;
        bit same;
        res = frame_result_of(m);
        acc = 1'b0;
        hist.push_back(res);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != res) same = 1'b0;
            if (same) stable_m = res;
        end
        if (stable_m < 0) begin
            held_m = -1;
        end else if (stable_m != held_m) begin
            acc    = 1'b1;
            held_m = stable_m;
            key_m  = 4'(stable_m);
        end
        if (clr_b) digits_m = '0;
        else if (acc) digits_m = {digits_m[27:0], key_m};
        return acc;
    endfunction

    task automatic do_reset(input string name);
        @(negedge ck);
        rst_n = 1'b0;
        repeat (2) @(negedge ck);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL %s col got %b exp 1110", name, col); end
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL %s key got %h exp 0", name, key); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL %s key_valid got %b exp 0", name, key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL %s key_held got %b exp 0", name, key_held); end
        checks++; if (digits !== 32'h0) begin errors++; $display("FAIL %s digits got %h exp 0", name, digits); end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Apply a key mask for one frame starting at a frame boundary; clr_b pulses
    // clr on the frame-end edge. Checks outputs at the following boundary.
    task automatic run_frame(input logic [15:0] m, input bit clr_b, input string name);
        int  c3;
        int  extra;
        bit  done;
        bit  exp_acc;
        c3    = 0;
        extra = 0;
        done  = 1'b0;
        mask  = m;
        for (int i = 0; i < FRAME + 4 && !done; i++) begin
            @(negedge ck);
            if (col === 4'b0111) begin
                c3++;
                if (c3 == SCAN_DIV) clr = clr_b;
            end else if (c3 > 0 && col === 4'b1110) begin
                done = 1'b1;
            end
            if (!done && key_valid === 1'b1) extra++;
        end
        clr = 1'b0;
        exp_acc = model_frame(m, clr_b);
        checks++; if (!done) begin errors++; $display("FAIL %s frame_end not seen within %0d cycles", name, FRAME + 4); end
        checks++; if (key_valid !== exp_acc) begin errors++; $display("FAIL %s key_valid got %b exp %b", name, key_valid, exp_acc); end
        checks++; if (key !== key_m) begin errors++; $display("FAIL %s key got %h exp %h", name, key, key_m); end
        checks++; if (key_held !== (held_m >= 0)) begin errors++; $display("FAIL %s key_held got %b exp %b", name, key_held, held_m >= 0); end
        checks++; if (digits !== digits_m) begin errors++; $display("FAIL %s digits got %h exp %h", name, digits, digits_m); end
        checks++; if (extra != 0) begin errors++; $display("FAIL %s stray key_valid pulses got %0d exp 0", name, extra); end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        do_reset("reset");
        for (int k = 0; k <= 2 * FRAME; k++) begin
            if (k > 0) @(negedge ck);
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            checks++;
            if (col !== exp_col) begin errors++; $display("FAIL col_step k=%0d got %b exp %b", k, col, exp_col); end
        end
        do_reset("reset_again");
    endtask

    task automatic test_single_press();
        for (int f = 0; f < 4; f++) run_frame(16'(1) << 6, 1'b0, "press_6");
        checks++; if (digits !== 32'h0000_0006) begin errors++; $display("FAIL press_6_digits got %h exp 00000006", digits); end
        for (int f = 0; f < 4; f++) run_frame('0, 1'b0, "release_6");
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 4; f++) run_frame((f % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0, "bounce_toggle");
        for (int f = 0; f < 4; f++) run_frame(16'h0001, 1'b0, "bounce_hold");
        for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "bounce_release");
    endtask

    task automatic test_multi_press();
        for (int f = 0; f < 5; f++) run_frame(16'h0001 | (16'(1) << 9), 1'b0, "multi_press");
        for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "multi_release");
    endtask

    task automatic test_digit_entry();
        for (int d = 1; d <= 9; d++) begin
            for (int f = 0; f < 3; f++) run_frame(mask_of(d), 1'b0, "entry_press");
            for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "entry_release");
        end
        checks++; if (digits !== 32'h2345_6789) begin errors++; $display("FAIL entry_digits got %h exp 23456789", digits); end
        for (int f = 0; f < 3; f++) run_frame(mask_of(7), f == 2, "entry_clr");
        checks++; if (digits !== 32'h0) begin errors++; $display("FAIL clr_accept_digits got %h exp 0", digits); end
        checks++; if (key !== 4'h7) begin errors++; $display("FAIL clr_accept_key got %h exp 7", key); end
        for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "entry_clr_release");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) run_frame(mask_of(5), 1'b0, "slide_5");
        for (int f = 0; f < 3; f++) run_frame(mask_of(8), 1'b0, "slide_8");
        checks++; if (digits[7:0] !== 8'h58) begin errors++; $display("FAIL slide_digits got %h exp ..58", digits[7:0]); end
        for (int f = 0; f < 2; f++) run_frame(mask_of(3), 1'b0, "pre_reset_3");
        repeat (6) @(negedge ck);
        do_reset("mid_debounce_reset");
        for (int f = 0; f < 3; f++) run_frame(mask_of(3), 1'b0, "held_through_reset");
        checks++; if (digits !== 32'h3) begin errors++; $display("FAIL reaccept_digits got %h exp 00000003", digits); end
    endtask

    task automatic test_random();
        logic [15:0] m;
        int kind;
        int len;
        int b1;
        int b2;
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 3);
            b1   = $urandom_range(0, 15);
            b2   = (b1 + $urandom_range(1, 15)) % 16;
            case (kind)
                0:       m = '0;
                3:       m = (16'(1) << b1) | (16'(1) << b2);
                default: m = 16'(1) << b1;
            endcase
            len = $urandom_range(1, 5);
            for (int f = 0; f < len; f++) run_frame(m, $urandom_range(0, 7) == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_press();
        test_digit_entry();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
